// File: rtl/cla16_arbiter.sv
// Round-robin front end for a shared W-bit adder: grants one requester per cycle,
// registers operands (stage 1) and result (stage 2), and returns tagged responses.
module cla16_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ-1:0]     req_cin,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_sum,
    output logic                rsp_cout,
    output logic                busy
);

    function automatic logic [W:0] cla_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    logic [IDW-1:0] ptr;

    logic           vld_p1;
    logic [IDW-1:0] id_p1;
    logic [W-1:0]   a_p1;
    logic [W-1:0]   b_p1;
    logic           cin_p1;

    logic           vld_p2;
    logic [IDW-1:0] id_p2;
    logic [W-1:0]   sum_p2;
    logic           cout_p2;

    logic           wrap_found;
    logic [IDW-1:0] wrap_id;
    logic           fwd_found;
    logic [IDW-1:0] fwd_id;
    logic [IDW-1:0] cand_id;
    logic [IDW-1:0] ptr_nxt;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           cin_sel;
    logic [W:0]     add_res;
    logic           s2_free;
    logic           s1_move;
    logic           s1_accept;
    logic           take;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        wrap_found = 1'b0;
        wrap_id    = '0;
        fwd_found  = 1'b0;
        fwd_id     = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                wrap_found = 1'b1;
                wrap_id    = IDW'(j);
                if (IDW'(j) >= ptr) begin
                    fwd_found = 1'b1;
                    fwd_id    = IDW'(j);
                end
            end
        end
    end

    assign cand_id   = fwd_found ? fwd_id : wrap_id;
    assign ptr_nxt   = (cand_id == IDW'(NREQ - 1)) ? '0 : cand_id + 1'b1;

    assign s2_free   = !vld_p2 || rsp_ready;
    assign s1_move   = vld_p1 && s2_free;
    assign s1_accept = !vld_p1 || s1_move;
    assign take      = wrap_found && s1_accept && !rst;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        cin_sel   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (IDW'(j) == cand_id) begin
                req_ready[j] = take;
                a_sel        = req_a[j*W +: W];
                b_sel        = req_b[j*W +: W];
                cin_sel      = req_cin[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= ptr_nxt;
        end
    end

    // Stage 1: operand register feeding the adder
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (take) begin
            vld_p1 <= 1'b1;
        end else if (s1_move) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            id_p1  <= cand_id;
            a_p1   <= a_sel;
            b_p1   <= b_sel;
            cin_p1 <= cin_sel;
        end
    end

    assign add_res = cla_add(a_p1, b_p1, cin_p1);

    // Stage 2: result register driving the response channel
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            id_p2   <= '0;
            sum_p2  <= '0;
            cout_p2 <= 1'b0;
        end else if (s1_move) begin
            vld_p2  <= 1'b1;
            id_p2   <= id_p1;
            sum_p2  <= add_res[W-1:0];
            cout_p2 <= add_res[W];
        end else if (vld_p2 && rsp_ready) begin
            vld_p2  <= 1'b0;
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_id    = id_p2;
    assign rsp_sum   = sum_p2;
    assign rsp_cout  = cout_p2;
    assign busy      = vld_p1 || vld_p2;

endmodule
